// File: rtl/mul_intn_seq.sv
// Sequential shift-add integer multiplier: retires one multiplier bit per cycle,
// signed/unsigned operands, optional full-width product, valid/ready on both sides.
module mul_intn_seq #(
  parameter int WIDTH     = 8,
  parameter bit FULL_PROD = 1'b0,
  localparam int POUT     = FULL_PROD ? 2 * WIDTH : WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POUT-1:0]  P,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic                 sgn_reg;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;

  logic                 last;
  logic [2*WIDTH-1:0]   ext;
  logic [2*WIDTH-1:0]   pp_sh;
  logic [2*WIDTH-1:0]   acc_nxt;

  // The multiplier MSB carries negative weight in signed mode, hence the subtract.
  always_comb begin
    last    = (cnt == CW'(WIDTH - 1));
    ext     = sgn_reg ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
    pp_sh   = b_reg[cnt] ? (ext << cnt) : '0;
    acc_nxt = (sgn_reg && last) ? (acc - pp_sh) : (acc + pp_sh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      P         <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sgn_reg   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B;
            sgn_reg  <= is_signed;
            acc      <= '0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          if (last) begin
            state     <= DONE;
            P         <= acc_nxt[POUT-1:0];
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_intn_seq.sv
// Scoreboard bench for mul_intn_seq: two WIDTH=8 instances (truncated and full
// product) driven in lockstep; a negedge monitor pops expected results on handshake.
module tb_mul_intn_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        is_signed;
  logic        out_ready;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic        busy0, busy1;
  logic [7:0]  P0;
  logic [15:0] P1;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rand_rdy = 1'b0;
  logic [7:0]  q8[$];
  logic [15:0] q16[$];

  mul_intn_seq #(.WIDTH(8), .FULL_PROD(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .A(A), .B(B), .is_signed(is_signed), .out_valid(out_valid0),
    .out_ready(out_ready), .P(P0), .busy(busy0)
  );

  mul_intn_seq #(.WIDTH(8), .FULL_PROD(1'b1)) u_full (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .A(A), .B(B), .is_signed(is_signed), .out_valid(out_valid1),
    .out_ready(out_ready), .P(P1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rand_rdy) begin
    #1 out_ready = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: the handshake completes on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid1 === 1'b1 && out_ready === 1'b1) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%h expected=none", P1);
      end else begin
        logic [7:0]  e8;
        logic [15:0] e16;
        e8  = q8.pop_front();
        e16 = q16.pop_front();
        chk("p_trunc", {24'd0, P0}, {24'd0, e8});
        chk("p_full", {16'd0, P1}, {16'd0, e16});
        chk("valid_lockstep", {31'd0, out_valid0}, 32'd1);
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [7:0] e8, input logic [15:0] e16, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    A = a; B = b; is_signed = s; in_valid = 1'b1;
    while (in_ready1 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready1 !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=in_ready_low expected=accept");
      in_valid = 1'b0;
      acc_cyc = -1;
    end else begin
      q8.push_back(e8);
      q16.push_back(e16);
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      in_valid = 1'b0;
      A = 8'($urandom);
      B = 8'($urandom);
      is_signed = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q16.size() != 0 || out_valid1 === 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q16.size(), 32'd0);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [7:0]  e8;
    logic [15:0] e16;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, n;
    vecs[0] = '{8'h0D, 8'h0B, 1'b0, 8'h8F, 16'h008F};
    vecs[1] = '{8'hFF, 8'hFF, 1'b0, 8'h01, 16'hFE01};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'h01, 16'h0001};
    vecs[3] = '{8'h80, 8'h80, 1'b1, 8'h00, 16'h4000};
    vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h80, 16'hC080};
    vecs[5] = '{8'h00, 8'h5A, 1'b0, 8'h00, 16'h0000};
    vecs[6] = '{8'h7F, 8'h7F, 1'b1, 8'h01, 16'h3F01};
    vecs[7] = '{8'h80, 8'h7F, 1'b0, 8'h80, 16'h3F80};
    vecs[8] = '{8'h03, 8'hFE, 1'b1, 8'hFA, 16'hFFFA};
    vecs[9] = '{8'h03, 8'hFE, 1'b0, 8'hFA, 16'h02FA};

    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; is_signed = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready1}, 32'd1);
    chk("rst_out_valid", {30'd0, out_valid1, out_valid0}, 32'd0);
    chk("rst_busy", {30'd0, busy1, busy0}, 32'd0);
    chk("rst_p", {8'd0, P0, P1}, 32'd0);
    rst_n = 1'b1;

    // Latency: out_valid is first seen on the 9th falling edge after the accept edge.
    issue(vecs[0].a, vecs[0].b, vecs[0].s, vecs[0].e8, vecs[0].e16, t0);
    n = 0;
    while (out_valid1 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 32'd9);
    drain();

    for (int i = 1; i < 10; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].e8, vecs[i].e16, t0);
      drain();
    end

    // Back-to-back throughput.
    issue(8'h0D, 8'h0B, 1'b0, 8'h8F, 16'h008F, t0);
    issue(8'hFF, 8'hFF, 1'b1, 8'h01, 16'h0001, t1);
    issue(8'h80, 8'h7F, 1'b1, 8'h80, 16'hC080, t2);
    chk("spacing_1", t1 - t0, 32'd10);
    chk("spacing_2", t2 - t1, 32'd10);
    drain();

    // Backpressure in DONE.
    out_ready = 1'b0;
    issue(8'h0D, 8'h0B, 1'b0, 8'h8F, 16'h008F, t0);
    n = 0;
    while (out_valid1 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; A = 8'h55; B = 8'h66; is_signed = 1'b1;
      @(negedge clk);
      chk("bp_valid", {31'd0, out_valid1}, 32'd1);
      chk("bp_p", {8'd0, P0, P1}, {8'd0, 8'h8F, 16'h008F});
      chk("bp_in_ready", {30'd0, in_ready1, in_ready0}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    issue(8'h7F, 8'h7F, 1'b0, 8'h01, 16'h3F01, t0);
    drain();

    // Reset in the middle of a job, at cnt=4.
    issue(8'h7F, 8'h7F, 1'b1, 8'h01, 16'h3F01, t0);
    repeat (4) @(posedge clk);
    #2;
    chk("busy_before_rst", {31'd0, busy1}, 32'd1);
    rst_n = 1'b0;
    #1;
    q8.delete();
    q16.delete();
    chk("arst_in_ready", {30'd0, in_ready1, in_ready0}, 32'd3);
    chk("arst_out_valid", {30'd0, out_valid1, out_valid0}, 32'd0);
    chk("arst_busy", {30'd0, busy1, busy0}, 32'd0);
    chk("arst_p", {8'd0, P0, P1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(8'h03, 8'hFE, 1'b1, 8'hFA, 16'hFFFA, t0);
    drain();

    // Random vectors under random output stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [7:0]  ra, rb;
      logic        rs;
      logic [15:0] g;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      if (rs) g = 16'({{8{ra[7]}}, ra} * {{8{rb[7]}}, rb});
      else    g = 16'({8'd0, ra} * {8'd0, rb});
      issue(ra, rb, rs, g[7:0], g, t0);
    end
    drain();
    rand_rdy = 1'b0;
    #2;
    out_ready = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
